fifo_ring: RTL and testbench
============================

# fifo_ring

Parametrised ring-buffer stream FIFO, the next generation of our shift-register stream FIFO. It replaces per-pop data shifting with read/write pointers into a dual-port memory. It adds programmable almost-full/almost-empty flags, a synchronous flush, and an optional peak-occupancy watermark. It sits between any two valid/ready stream stages and buffers bursts.

## Interface
- DATA_WIDTH, 32, payload width in bits, ≥1
- FIFO_DEPTH, 8, entry count; power of two, ≥2
- AFULL_THRESH, FIFO_DEPTH-2, almostFull asserts when count ≥ this value
- AEMPTY_THRESH, 1, almostEmpty asserts when count ≤ this value
- CW = $clog2(FIFO_DEPTH)+1: localparam, count width
- clk  in  1  sole clock; all flops on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents
- dataIn  in  DATA_WIDTH  write payload
- dataInValid  in  1  write request
- dataInReady  out  1  FIFO can accept
- dataOut  out  DATA_WIDTH  head entry
- dataOutValid  out  1  head entry valid
- dataOutReady  in  1  consumer accepts head
- count  out  CW  current occupancy, 0..FIFO_DEPTH
- almostFull  out  1  count ≥ AFULL_THRESH
- almostEmpty  out  1  count ≤ AEMPTY_THRESH
- peakCount  out  CW  maximum occupancy since reset

## Operation
- State: wrPtr and rdPtr, each CW bits with a wrap bit; count register; initDone flag.
  - Memory address is ptr[CW-2:0].
  - full = (wrPtr ^ rdPtr) == {1'b1, 0…}; empty = wrPtr == rdPtr.
- push = dataInValid & dataInReady; pop = dataOutValid & dataOutReady.
- dataInReady = initDone & ~full. dataOutValid = ~empty.
- dataOut = mem[rdPtr]; first-word fall-through, no output register.
- Per cycle, with flush low:
  - push writes mem[wrPtr] and increments wrPtr.
  - pop increments rdPtr.
  - count changes +1 for push only, −1 for pop only, 0 for both or neither.
- Full: dataInReady is 0 even if a pop occurs that cycle. There is no full-bypass.
- Empty: a push is not visible on dataOut in the same cycle. There is no empty-bypass.
- flush high: next cycle wrPtr = rdPtr = 0 and count = 0. Flush overrides push and pop, so data offered in the flush cycle is discarded. Memory contents are not cleared.
- Pointer wrap modulo 2·FIFO_DEPTH is natural overflow; no special handling.
- Thresholds outside 0..FIFO_DEPTH are a parameter error; elaboration fails via assertion.

## Timing
- Reset values: dataInReady 0, dataOutValid 0, count 0, almostFull 0, almostEmpty 1, peakCount 0.
- dataOut is don't-care while dataOutValid = 0. The memory has no reset.
- initDone sets on the first rising edge after resetn deasserts. dataInReady therefore rises one cycle after reset release.
- Write-to-read latency is 1 cycle: push in cycle N gives dataOutValid = 1 and the new head in cycle N+1.
- count, almostFull, almostEmpty and peakCount are registered or derived from registers; they update 1 cycle after the causing push or pop.
- dataInReady and dataOutValid depend only on registers, with no combinational path from dataInValid or dataOutReady.
- Once asserted, dataOutValid stays high until a pop or flush. dataOut stays stable while valid and not popped.
- resetn asserted mid-transfer: all state clears immediately and asynchronously. In-flight data is lost.

## Configuration
- FIFO_RING_WATERMARK_EN defined:
  - peakCount register updates to max(peakCount, next count) every cycle.
  - Cleared by reset only; flush does not clear it.
- Not defined: peakCount is tied to 0 and no register is synthesised. The port list is unchanged.

## Structure
- Package fifo_ring_pkg holds:
  - fifo_status_t, a packed struct {full, empty, almostFull, almostEmpty} used internally and by monitors;
  - default parameter constants;
  - function isPow2 for parameter checks.
- Sub-module fifo_ring_mem: simple dual-port, one synchronous write port, one asynchronous read port, parameterised by DATA_WIDTH and FIFO_DEPTH.
- Top-level fifo_ring holds pointers, count, flags, handshake and watermark logic.

## Test plan
- Reset release with dataInValid = 1: dataInReady = 0 in the first post-reset cycle and 1 in the next. count = 0, almostEmpty = 1.
- Fill DEPTH=8 with values 0x10..0x17, dataOutReady = 0:
  - count reaches 8 and dataInReady drops after the 8th push;
  - almostFull rises when count = 6;
  - a 9th value of 0x99 is not accepted.
- Drain the full FIFO with dataOutReady = 1: dataOut sequence is 0x10..0x17, then dataOutValid = 0. count = 0, with no duplicates.
- Steady push and pop for 40 cycles of incrementing data at count = 3:
  - count stays at 3;
  - output order is preserved across ≥4 pointer wraps.
- flush asserted at count = 5 with a simultaneous push of 0xAA: next cycle count = 0, dataOutValid = 0, and 0xAA never appears on dataOut.
- With FIFO_RING_WATERMARK_EN: push 6, pop 6, push 2 → peakCount = 6; a subsequent flush keeps 6. Without the macro, peakCount stays 0.

Source files
------------

// File: rtl/fifo_ring_pkg.sv
// fifo_ring_pkg: shared types, default parameters and parameter-check helpers
// for the fifo_ring stream FIFO.
package fifo_ring_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    // Occupancy status bundle, used inside the FIFO and by external monitors.
    typedef struct packed {
        logic full;
        logic empty;
        logic almostFull;
        logic almostEmpty;
    } fifo_status_t;

    // True when v is a positive power of two.
    function automatic bit isPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ring_mem.sv
// fifo_ring_mem: simple dual-port storage, synchronous write, asynchronous read.
// No reset: contents are undefined until written.
module fifo_ring_mem
    import fifo_ring_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Write port: one entry per cycle on the rising edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ring.sv
// fifo_ring: ring-buffer valid/ready stream FIFO with first-word fall-through,
// almost-full/almost-empty flags and synchronous flush.
// Optional peak-occupancy watermark enabled by defining FIFO_RING_WATERMARK_EN;
// without it peakCount is tied to zero.
module fifo_ring
    import fifo_ring_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataInValid,
    output logic                  dataInReady,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataOutValid,
    input  logic                  dataOutReady,
    output logic [CW-1:0]         count,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic [CW-1:0]         peakCount
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] FULL_XOR = CW'(FIFO_DEPTH);   // wrap bits differ, address equal
    localparam logic [CW-1:0] AF_T     = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_T     = CW'(AEMPTY_THRESH);

    if (DATA_WIDTH < 1 || FIFO_DEPTH < 2 || !isPow2(FIFO_DEPTH) ||
        AFULL_THRESH < 0 || AFULL_THRESH > FIFO_DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH) begin : g_param_err
        $fatal(1, "fifo_ring: illegal parameter set");
    end

    logic [CW-1:0] wrPtr, rdPtr, countNext;
    logic          initDone, push, pop;
    fifo_status_t  status;

    assign status.full        = (wrPtr ^ rdPtr) == FULL_XOR;
    assign status.empty       = wrPtr == rdPtr;
    assign status.almostFull  = count >= AF_T;
    assign status.almostEmpty = count <= AE_T;

    // Handshake depends on registered state only; no bypass in either direction.
    assign dataInReady  = initDone & ~status.full;
    assign dataOutValid = ~status.empty;
    assign almostFull   = status.almostFull;
    assign almostEmpty  = status.almostEmpty;

    assign push = dataInValid & dataInReady;
    assign pop  = dataOutValid & dataOutReady;

    fifo_ring_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push & ~flush),
        .waddr(wrPtr[AW-1:0]),
        .wdata(dataIn),
        .raddr(rdPtr[AW-1:0]),
        .rdata(dataOut)
    );

    // Next occupancy: flush wins, simultaneous push+pop cancel.
    always_comb begin
        countNext = count;
        if (flush)              countNext = '0;
        else if (push && !pop)  countNext = count + CW'(1);
        else if (pop && !push)  countNext = count - CW'(1);
    end

    // Pointer, count and init-done state; pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            initDone <= 1'b0;
        end else begin
            initDone <= 1'b1;
            count    <= countNext;
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + CW'(1);
                if (pop)  rdPtr <= rdPtr + CW'(1);
            end
        end
    end

`ifdef FIFO_RING_WATERMARK_EN
    // Peak occupancy tracker; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                    peakCount <= '0;
        else if (countNext > peakCount) peakCount <= countNext;
    end
`else
    assign peakCount = '0;
`endif

endmodule

// File: tb/tb_fifo_ring.sv
// tb_fifo_ring: directed self-checking bench for fifo_ring (DEPTH 8, 32-bit).
module tb_fifo_ring;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int CW = 4;
`ifdef FIFO_RING_WATERMARK_EN
    localparam int PEAK6 = 6;
`else
    localparam int PEAK6 = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn, flush, dataInValid, dataInReady;
    logic          dataOutValid, dataOutReady, almostFull, almostEmpty;
    logic [DW-1:0] dataIn, dataOut;
    logic [CW-1:0] count, peakCount;

    int nAsserts = 0;
    int nFails = 0;

    fifo_ring #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .dataIn(dataIn), .dataInValid(dataInValid), .dataInReady(dataInReady),
        .dataOut(dataOut), .dataOutValid(dataOutValid), .dataOutReady(dataOutReady),
        .count(count), .almostFull(almostFull), .almostEmpty(almostEmpty),
        .peakCount(peakCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; dataIn = 32'h55; dataInValid = 1'b1; dataOutReady = 1'b0;
        tick(); tick();
        chk("rst_inready", dataInReady, 0);
        chk("rst_outvalid", dataOutValid, 0);
        chk("rst_count", count, 0);
        chk("rst_afull", almostFull, 0);
        chk("rst_aempty", almostEmpty, 1);
        chk("rst_peak", peakCount, 0);

        // Release reset with a pending write; ready must lag by one cycle.
        resetn = 1'b1;
        #1;
        chk("post_rst_inready0", dataInReady, 0);
        tick();
        chk("post_rst_inready1", dataInReady, 1);
        chk("post_rst_count", count, 0);
        chk("post_rst_aempty", almostEmpty, 1);
        dataInValid = 1'b0;

        // Fill with 0x10..0x17.
        for (int i = 0; i < DEPTH; i++) begin
            dataIn = 32'h10 + 32'(i); dataInValid = 1'b1;
            tick();
            chk("fill_count", count, 64'(i + 1));
            chk("fill_afull", almostFull, (i + 1) >= 6);
            chk("fill_inready", dataInReady, (i + 1) < DEPTH);
        end
        dataIn = 32'h99;
        tick(); tick();
        chk("full_count", count, 8);
        chk("full_inready", dataInReady, 0);
        chk("full_head", dataOut, 32'h10);
        dataInValid = 1'b0;

        // Drain: expect exactly 0x10..0x17.
        dataOutReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", dataOutValid, 1);
            chk("drain_data", dataOut, 32'h10 + 32'(i));
            tick();
        end
        chk("drained_valid", dataOutValid, 0);
        chk("drained_count", count, 0);
        chk("drained_aempty", almostEmpty, 1);
        dataOutReady = 1'b0;

        // Preload 3 then stream 40 cycles at constant occupancy.
        for (int i = 0; i < 3; i++) begin
            dataIn = 32'h100 + 32'(i); dataInValid = 1'b1;
            tick();
        end
        chk("steady_pre_count", count, 3);
        dataOutReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            dataIn = 32'h103 + 32'(i);
            chk("steady_data", dataOut, 32'h100 + 32'(i));
            chk("steady_count", count, 3);
            tick();
        end
        dataInValid = 1'b0; dataOutReady = 1'b0;
        chk("steady_post_count", count, 3);
        chk("steady_post_head", dataOut, 32'h128);

        // Bring occupancy to 5, then flush with a concurrent push of 0xAA.
        for (int i = 0; i < 2; i++) begin
            dataIn = 32'h12B + 32'(i); dataInValid = 1'b1;
            tick();
        end
        chk("preflush_count", count, 5);
        chk("preflush_afull", almostFull, 0);
        flush = 1'b1; dataIn = 32'hAA;
        tick();
        flush = 1'b0; dataInValid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", dataOutValid, 0);
        chk("flush_inready", dataInReady, 1);
        dataIn = 32'h33; dataInValid = 1'b1;
        tick();
        dataInValid = 1'b0;
        chk("postflush_valid", dataOutValid, 1);
        chk("postflush_data", dataOut, 32'h33);
        chk("postflush_count", count, 1);

        // Asynchronous reset mid-stream clears state immediately.
        resetn = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", dataOutValid, 0);
        chk("async_rst_inready", dataInReady, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Watermark: push 6, pop 6, push 2.
        dataInValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dataIn = 32'h200 + 32'(i);
            tick();
        end
        dataInValid = 1'b0;
        chk("wm_count6", count, 6);
        dataOutReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("wm_pop_data", dataOut, 32'h200 + 32'(i));
            tick();
        end
        dataOutReady = 1'b0;
        dataInValid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dataIn = 32'h300 + 32'(i);
            tick();
        end
        dataInValid = 1'b0;
        chk("wm_count2", count, 2);
        chk("wm_aempty", almostEmpty, 0);
        chk("wm_peak", peakCount, 64'(PEAK6));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wm_flush_count", count, 0);
        chk("wm_flush_peak", peakCount, 64'(PEAK6));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
